dphy_tx_lane: RTL and testbench
===============================

Name: dphy_tx_lane

Overview:
- Single MIPI D-PHY data-lane transmitter; the transmit counterpart of the lane input SERDES path.
- Sequences LP-11 -> LP-01 -> LP-00 -> HS-prepare -> HS-zero -> sync byte -> payload -> HS-trail -> LP-11.
- Serialises payload bytes LSB-first into 2 bits per dphy_clk, for an arch-specific DDR output primitive.
- Runs entirely on dphy_clk; upstream supplies bytes in the dphy_clk domain (CDC from sys_clk is upstream's job).

Parameters:
- T_LPX, 16, dphy_clk cycles spent in each of LP-01 and LP-00.
- T_HS_PREPARE, 16, dphy_clk cycles of HS-0 with hs_oe=1 before the first zero byte; minimum 1.
- T_HS_ZERO, 6, number of 0x00 bytes sent before sync; minimum 1.
- T_HS_TRAIL, 4, number of trail bytes after the last payload byte; minimum 1.
- T_HS_EXIT, 32, dphy_clk cycles in LP-11 after a burst before hs_req is sampled again.

Ports:
- dphy_clk  in  1  fast D-PHY DDR bit clock.
- areset  in  1  reset: asynchronous, active-high; clock dphy_clk.
- hs_req  in  1  level request for an HS burst; sampled only in IDLE.
- byte_data  in  8  payload byte.
- byte_valid  in  1  payload byte valid.
- byte_ready  out  1  byte accepted when byte_valid && byte_ready.
- dout  out  2  to DDR output primitive; dout[0] is transmitted before dout[1].
- hs_oe  out  1  HS driver enable.
- lp_p  out  1  LP driver, P line.
- lp_n  out  1  LP driver, N line.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (asynchronous): state IDLE, lp_p=1, lp_n=1, hs_oe=0, dout=00, byte_ready=0, busy=0, shift register 0, phase 0. A reset mid-burst aborts immediately to these values; there is no trail.
- Shifter: 8-bit shreg.
  - dout = shreg[1:0], registered.
  - Each HS cycle, shreg shifts right by 2.
  - When phase==3, shreg loads the next byte instead of shifting.
  - phase is a 2-bit counter that wraps 3->0 and runs continuously from the end of PREPARE until TRAIL completes.
  - A byte loaded at cycle t appears on dout as [1:0],[3:2],[5:4],[7:6] at cycles t+1..t+4.
- IDLE: LP-11. If hs_req=1 -> LP01.
- LP01: lp_p=0, lp_n=1 for T_LPX cycles -> LP00.
- LP00: lp_p=0, lp_n=0 for T_LPX cycles -> PREPARE.
- PREPARE:
  - LP-00, hs_oe=1, dout=00 for T_HS_PREPARE cycles.
  - On the last cycle, load 0x00 and set phase=0 -> HS_ZERO.
- HS_ZERO: at each phase==3 load 0x00 until T_HS_ZERO zero bytes have been loaded in total (including the one loaded in PREPARE), then load the sync byte 0xB8 -> SYNC.
- SYNC:
  - byte_ready=1 on the phase==3 cycle only.
  - If byte_valid=1, load byte_data -> DATA.
  - Otherwise (empty burst) load the trail byte -> TRAIL.
- DATA:
  - byte_ready=1 exactly on phase==3 cycles; byte_ready=0 at all other times and in all other states.
  - Valid high: load byte_data and stay.
  - Valid low: load the first trail byte -> TRAIL. A gap in byte_valid ends the packet; upstream holds valid continuous within a packet.
- Trail byte: 0x00 if bit 7 of the last transmitted byte (payload byte, or sync for an empty burst) is 1; 0xFF otherwise. Record the MSB of the last byte loaded.
- TRAIL:
  - Loads T_HS_TRAIL trail bytes in total.
  - At the phase==3 cycle after the last trail byte has fully shifted out, hs_oe=0, lp=11 -> EXIT.
  - dout is driven 00 once out of HS.
- EXIT: LP-11 for T_HS_EXIT cycles -> IDLE. hs_req is ignored in EXIT.
- Back-to-back bursts: hs_req held high gives a new LP01 on the cycle after IDLE is entered. IDLE lasts exactly 1 cycle.
- busy=1 from the LP01 entry through the end of EXIT.
- Duration counters: a single down-counter sized for the largest parameter, clog2-based width; reloaded on every state entry.

Decomposition:
- Package dphy_tx_pkg holds:
  - state enum: IDLE, LP01, LP00, PREPARE, HS_ZERO, SYNC, DATA, TRAIL, EXIT;
  - constant SYNC_BYTE=8'hB8;
  - LP-state 2-bit codes LP11, LP01, LP00.
- One natural sub-module: dphy_oserdes_shifter. It contains the phase counter, shreg, load strobe and registered dout, and exposes load_req (phase==3) and load_data. The FSM lives in the top module.

Test Plan:
- Reset, then hold idle 100 cycles -> lp=11, hs_oe=0, dout=00, byte_ready=0, busy=0 throughout.
- Default params, hs_req pulse, single byte 0x5A -> lp=01 for 16 cycles and lp=00 for 16 cycles, then 16 cycles of dout=00 with hs_oe=1, then 24 cycles of dout=00. Then sync dout 00,10,11,10; payload dout 10,10,01,01; trail 0xFF gives dout=11 for 16 cycles; then LP-11 for 32 cycles.
- Payload 0x01,0x80,0xC3 back to back -> three byte_ready handshakes exactly 4 cycles apart. MSB of 0xC3 is 1, so trail=0x00.
- Empty burst (byte_valid=0) -> no handshake, trail=0x00 (sync MSB=1), burst length exact.
- hs_req held high -> after EXIT, IDLE lasts 1 cycle, then LP01; second burst identical to the first.
- areset asserted mid-DATA -> same cycle: hs_oe=0, lp=11, dout=00, byte_ready=0. After release, a new burst completes normally.

Source files
------------

// File: rtl/dphy_tx_pkg.sv
// Shared types and constants for the D-PHY data-lane transmitter.
package dphy_tx_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LP01,
        LP00,
        PREPARE,
        HS_ZERO,
        SYNC,
        DATA,
        TRAIL,
        EXIT
    } state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    // LP line codes, ordered {lp_p, lp_n}
    localparam logic [1:0] LP_11 = 2'b11;
    localparam logic [1:0] LP_01 = 2'b01;
    localparam logic [1:0] LP_00 = 2'b00;

endpackage

// File: rtl/dphy_tx_lane_shifter.sv
// 8:2 serialiser feeding the DDR output primitive; dout[0] goes out first.
module dphy_oserdes_shifter (
    input  logic       dphy_clk,
    input  logic       areset,
    input  logic       start,
    input  logic       run,
    input  logic [7:0] load_data,
    output logic       load_req,
    output logic       phase_pre,
    output logic [1:0] dout
);

    logic [1:0] phase;
    logic [7:0] shreg;

    assign load_req  = (phase == 2'd3);
    assign phase_pre = (phase == 2'd2);

    // shreg holds the bits still to be sent; dout already carries the current pair
    always_ff @(posedge dphy_clk or posedge areset) begin
        if (areset) begin
            phase <= 2'd0;
            shreg <= 8'h00;
            dout  <= 2'b00;
        end else if (start) begin
            phase <= 2'd0;
            shreg <= {2'b00, load_data[7:2]};
            dout  <= load_data[1:0];
        end else if (run) begin
            phase <= phase + 2'd1;
            if (load_req) begin
                shreg <= {2'b00, load_data[7:2]};
                dout  <= load_data[1:0];
            end else begin
                shreg <= shreg >> 2;
                dout  <= shreg[1:0];
            end
        end else begin
            phase <= 2'd0;
            shreg <= 8'h00;
            dout  <= 2'b00;
        end
    end

endmodule

// File: rtl/dphy_tx_lane.sv
// D-PHY data-lane transmitter: LP entry sequence, HS burst with sync/trail, LP exit.
module dphy_tx_lane
    import dphy_tx_pkg::*;
#(
    parameter int T_LPX        = 16,
    parameter int T_HS_PREPARE = 16,
    parameter int T_HS_ZERO    = 6,
    parameter int T_HS_TRAIL   = 4,
    parameter int T_HS_EXIT    = 32
) (
    input  logic       dphy_clk,
    input  logic       areset,
    input  logic       hs_req,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic [1:0] dout,
    output logic       hs_oe,
    output logic       lp_p,
    output logic       lp_n,
    output logic       busy,
    output state_e     dbg_state
);

    localparam int M_A     = (T_LPX > T_HS_PREPARE) ? T_LPX : T_HS_PREPARE;
    localparam int M_B     = (T_HS_ZERO > T_HS_TRAIL) ? T_HS_ZERO : T_HS_TRAIL;
    localparam int M_C     = (M_A > M_B) ? M_A : M_B;
    localparam int CNT_MAX = (M_C > T_HS_EXIT) ? M_C : T_HS_EXIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LPX_LD   = CNT_W'(T_LPX - 1);
    localparam logic [CNT_W-1:0] PREP_LD  = CNT_W'(T_HS_PREPARE - 1);
    localparam logic [CNT_W-1:0] ZERO_LD  = CNT_W'(T_HS_ZERO - 1);
    localparam logic [CNT_W-1:0] TRAIL_LD = CNT_W'(T_HS_TRAIL - 1);
    localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(T_HS_EXIT - 1);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             last_msb;
    logic [7:0]       trail_byte;
    logic [7:0]       load_data;
    logic             load_req;
    logic             phase_pre;
    logic             sh_start;
    logic             sh_run;

    assign dbg_state  = state;
    assign cnt_zero   = (cnt == '0);
    assign trail_byte = last_msb ? 8'h00 : 8'hFF;
    assign sh_start   = (state == PREPARE) && cnt_zero;
    // The last trail byte finishes on this load_req; stop instead of loading again
    assign sh_run     = (state inside {HS_ZERO, SYNC, DATA, TRAIL})
                        && !((state == TRAIL) && load_req && cnt_zero);

    always_comb begin
        load_data = 8'h00;
        case (state)
            HS_ZERO:    load_data = cnt_zero ? SYNC_BYTE : 8'h00;
            SYNC, DATA: load_data = byte_valid ? byte_data : trail_byte;
            TRAIL:      load_data = trail_byte;
            default:    load_data = 8'h00;
        endcase
    end

    dphy_oserdes_shifter u_shifter (
        .dphy_clk  (dphy_clk),
        .areset    (areset),
        .start     (sh_start),
        .run       (sh_run),
        .load_data (load_data),
        .load_req  (load_req),
        .phase_pre (phase_pre),
        .dout      (dout)
    );

    // Handshake: a byte transfers on a rising edge where byte_valid && byte_ready;
    // byte_ready is offered only on the phase==3 cycle of SYNC/DATA, and a low
    // byte_valid on that cycle ends the packet.
    always_ff @(posedge dphy_clk or posedge areset) begin
        if (areset) begin
            state        <= IDLE;
            cnt          <= '0;
            last_msb     <= 1'b0;
            {lp_p, lp_n} <= LP_11;
            hs_oe        <= 1'b0;
            busy         <= 1'b0;
            byte_ready   <= 1'b0;
        end else begin
            byte_ready <= ((state == SYNC) || (state == DATA)) && phase_pre;
            case (state)
                IDLE: begin
                    if (hs_req) begin
                        state        <= LP01;
                        cnt          <= LPX_LD;
                        {lp_p, lp_n} <= LP_01;
                        busy         <= 1'b1;
                    end
                end
                LP01: begin
                    if (cnt_zero) begin
                        state        <= LP00;
                        cnt          <= LPX_LD;
                        {lp_p, lp_n} <= LP_00;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                LP00: begin
                    if (cnt_zero) begin
                        state <= PREPARE;
                        cnt   <= PREP_LD;
                        hs_oe <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PREPARE: begin
                    if (cnt_zero) begin
                        state <= HS_ZERO;
                        cnt   <= ZERO_LD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HS_ZERO: begin
                    if (load_req) begin
                        if (cnt_zero) begin
                            state    <= SYNC;
                            last_msb <= SYNC_BYTE[7];
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                SYNC, DATA: begin
                    if (load_req) begin
                        if (byte_valid) begin
                            state    <= DATA;
                            last_msb <= byte_data[7];
                        end else begin
                            state <= TRAIL;
                            cnt   <= TRAIL_LD;
                        end
                    end
                end
                TRAIL: begin
                    if (load_req) begin
                        if (cnt_zero) begin
                            state        <= EXIT;
                            cnt          <= EXIT_LD;
                            hs_oe        <= 1'b0;
                            {lp_p, lp_n} <= LP_11;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                EXIT: begin
                    if (cnt_zero) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dphy_tx_lane.sv
// Bench for dphy_tx_lane: per-cycle comparison of the lane outputs against a burst waveform model.
module tb_dphy_tx_lane;
    import dphy_tx_pkg::*;

    localparam int T_LPX        = 16;
    localparam int T_HS_PREPARE = 16;
    localparam int T_HS_ZERO    = 6;
    localparam int T_HS_TRAIL   = 4;
    localparam int T_HS_EXIT    = 32;

    logic       dphy_clk = 1'b0;
    logic       areset;
    logic       hs_req;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    logic [1:0] dout;
    logic       hs_oe;
    logic       lp_p;
    logic       lp_n;
    logic       busy;
    state_e     dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int pay_idx = 0;

    // expected per-cycle vector: {lp_p, lp_n, hs_oe, dout[1:0], busy, byte_ready}
    logic [6:0] exp_q[$];
    logic [7:0] pay_q[$];

    dphy_tx_lane u_dut (
        .dphy_clk   (dphy_clk),
        .areset     (areset),
        .hs_req     (hs_req),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .dout       (dout),
        .hs_oe      (hs_oe),
        .lp_p       (lp_p),
        .lp_n       (lp_n),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    always #5 dphy_clk = ~dphy_clk;

    function automatic logic [6:0] vec(input logic [1:0] lp, input logic oe,
                                       input logic [1:0] d, input logic b, input logic br);
        return {lp, oe, d, b, br};
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Whole burst from LP01 entry to the single IDLE cycle after EXIT.
    task automatic model_burst();
        logic [7:0] bytes[$];
        logic       is_xfer[$];
        logic [7:0] last_b;
        logic [7:0] trail;
        logic [7:0] b;
        repeat (T_LPX)        exp_q.push_back(vec(2'b01, 1'b0, 2'b00, 1'b1, 1'b0));
        repeat (T_LPX)        exp_q.push_back(vec(2'b00, 1'b0, 2'b00, 1'b1, 1'b0));
        repeat (T_HS_PREPARE) exp_q.push_back(vec(2'b00, 1'b1, 2'b00, 1'b1, 1'b0));
        repeat (T_HS_ZERO) begin
            bytes.push_back(8'h00);
            is_xfer.push_back(1'b0);
        end
        bytes.push_back(8'hB8);
        is_xfer.push_back(1'b1);
        foreach (pay_q[i]) begin
            bytes.push_back(pay_q[i]);
            is_xfer.push_back(1'b1);
        end
        last_b = bytes[bytes.size() - 1];
        trail  = last_b[7] ? 8'h00 : 8'hFF;
        repeat (T_HS_TRAIL) begin
            bytes.push_back(trail);
            is_xfer.push_back(1'b0);
        end
        foreach (bytes[i]) begin
            b = bytes[i];
            for (int k = 0; k < 4; k++)
                exp_q.push_back(vec(2'b00, 1'b1, b[2*k +: 2], 1'b1, is_xfer[i] && (k == 3)));
        end
        repeat (T_HS_EXIT) exp_q.push_back(vec(2'b11, 1'b0, 2'b00, 1'b1, 1'b0));
        exp_q.push_back(vec(2'b11, 1'b0, 2'b00, 1'b0, 1'b0));
    endtask

    task automatic prep_burst();
        pay_idx    = 0;
        byte_valid = (pay_q.size() > 0);
        byte_data  = (pay_q.size() > 0) ? pay_q[0] : 8'h00;
        model_burst();
    endtask

    // Called just after a rising edge with the DUT in IDLE; returns after LP01 entry.
    task automatic start_burst(input logic hold);
        prep_burst();
        hs_req = 1'b1;
        @(posedge dphy_clk); #1;
        if (!hold) hs_req = 1'b0;
    endtask

    task automatic run_expected(input string tag, input int lim);
        int         n;
        logic       hs;
        logic [6:0] e;
        n = 0;
        while (exp_q.size() > 0 && (lim < 0 || n < lim)) begin
            e = exp_q.pop_front();
            @(negedge dphy_clk);
            check(tag, {lp_p, lp_n, hs_oe, dout, busy, byte_ready}, e);
            hs = byte_ready && byte_valid;
            @(posedge dphy_clk); #1;
            if (hs) begin
                pay_idx++;
                if (pay_idx < pay_q.size()) begin
                    byte_data = pay_q[pay_idx];
                end else begin
                    byte_valid = 1'b0;
                    byte_data  = 8'h00;
                end
            end
            n++;
        end
    endtask

    initial begin
        areset     = 1'b1;
        hs_req     = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        #2;
        check("reset_outputs", {lp_p, lp_n, hs_oe, dout, busy, byte_ready},
              vec(2'b11, 1'b0, 2'b00, 1'b0, 1'b0));
        check_int("reset_state", int'(dbg_state), int'(IDLE));
        repeat (3) @(posedge dphy_clk);
        #1 areset = 1'b0;

        repeat (100) exp_q.push_back(vec(2'b11, 1'b0, 2'b00, 1'b0, 1'b0));
        run_expected("idle_hold", -1);

        pay_q = '{8'h5A};
        start_burst(1'b0);
        run_expected("single_5a", -1);
        check_int("single_5a_handshakes", pay_idx, 1);

        pay_q = '{8'h01, 8'h80, 8'hC3};
        start_burst(1'b0);
        run_expected("three_bytes", -1);
        check_int("three_bytes_handshakes", pay_idx, 3);

        pay_q.delete();
        start_burst(1'b0);
        run_expected("empty_burst", -1);
        check_int("empty_handshakes", pay_idx, 0);

        pay_q = '{8'h3C, 8'hA7};
        start_burst(1'b1);
        run_expected("b2b_first", -1);
        hs_req = 1'b0;
        prep_burst();
        run_expected("b2b_second", -1);

        repeat (5) begin
            int n;
            n = $urandom_range(1, 6);
            pay_q.delete();
            repeat (n) pay_q.push_back(8'($urandom_range(0, 255)));
            start_burst(1'b0);
            run_expected("random_burst", -1);
            check_int("random_handshakes", pay_idx, n);
        end

        pay_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        start_burst(1'b0);
        run_expected("pre_reset", 3 * T_LPX + 4 * T_HS_ZERO + 4 + 6);
        exp_q.delete();
        areset = 1'b1;
        #1;
        check("midburst_reset", {lp_p, lp_n, hs_oe, dout, busy, byte_ready},
              vec(2'b11, 1'b0, 2'b00, 1'b0, 1'b0));
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (2) @(posedge dphy_clk);
        #1 areset = 1'b0;
        @(posedge dphy_clk); #1;

        pay_q = '{8'h96, 8'h7E};
        start_burst(1'b0);
        run_expected("after_reset", -1);
        check_int("after_reset_handshakes", pay_idx, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
